seq_cfg_loader: RTL and testbench

Configuration front-end for the serial sequence detector. Accepts a byte-wide, valid/ready command stream and assembles a MAX_N-bit match pattern plus 5-bit sequence length in shadow registers. On a validated commit it atomically updates the active `pattern`/`seq_len` outputs that drive the detector's compare, and pulses `det_flush` so the detector discards history gathered under the old configuration.

---
 rtl/seq_det_pkg.sv | 21 ++
 rtl/seq_cfg_loader.sv | 136 +++++++++++++
 tb/tb_seq_cfg_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and sizing for the sequence detector and its config loader.
// Command encodings and loader state encoding live here.
package seq_det_pkg;

  localparam int MAX_N = 32;

  typedef enum logic [1:0] {
    CLEAR     = 2'b00,
    LOAD_LEN  = 2'b01,
    LOAD_BYTE = 2'b10,
    COMMIT    = 2'b11
  } cfg_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL,
    APPLY
  } ld_state_t;

endpackage

// File: rtl/seq_cfg_loader.sv
// Config loader: assembles pattern/length in shadow regs and
// commits them atomically to the detector with a flush pulse.
module seq_cfg_loader #(
  parameter int MAX_N = seq_det_pkg::MAX_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_cmd,
  input  logic [7:0]       cfg_data,
  output logic [MAX_N-1:0] pattern,
  output logic [4:0]       seq_len,
  output logic             armed,
  output logic             det_flush,
  output logic             cfg_err,
  output logic [2:0]       byte_cnt
);

  import seq_det_pkg::*;

  localparam int NBYTES = MAX_N / 8;
  localparam logic [2:0] CNT_FULL = 3'(NBYTES);
  localparam logic [5:0] LEN_MAX = 6'(MAX_N);

  ld_state_t        state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [MAX_N-1:0] shadow_q, shadow_d;
  logic [4:0]       slen_q, slen_d;
  logic [MAX_N-1:0] pat_q, pat_d;
  logic [4:0]       len_q, len_d;
  logic             armed_q, armed_d;
  logic             flush_q, flush_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  cfg_cmd_t   cmd;
  logic       accept;
  logic       len_ok;
  logic [2:0] cnt_inc;

  assign cmd     = cfg_cmd_t'(cfg_cmd);
  assign accept  = cfg_valid && ready_q;
  assign cnt_inc = cnt_q + 3'd1;
  assign len_ok  = (cfg_data[7:5] == 3'd0) &&
                   ({1'b0, cfg_data[4:0]} <= LEN_MAX);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    slen_d   = slen_q;
    pat_d    = pat_q;
    len_d    = len_q;
    armed_d  = armed_q;
    flush_d  = 1'b0;
    err_d    = err_q;
    if (state_q == APPLY) begin
      pat_d   = shadow_q;
      len_d   = slen_q;
      armed_d = 1'b1;
      flush_d = 1'b1;
      cnt_d   = 3'd0;
      state_d = IDLE;
    end else if (accept) begin
      unique case (cmd)
        CLEAR: begin
          shadow_d = '0;
          slen_d   = '0;
          cnt_d    = 3'd0;
          err_d    = 1'b0;
          armed_d  = 1'b0;
          pat_d    = '0;
          len_d    = '0;
          flush_d  = 1'b1;
          state_d  = IDLE;
        end
        LOAD_LEN: begin
          if (len_ok) slen_d = cfg_data[4:0];
          else        err_d  = 1'b1;
        end
        LOAD_BYTE: begin
          if (cnt_q == CNT_FULL) begin
            err_d = 1'b1;
          end else begin
            // First byte loaded migrates up to the MSBs.
            shadow_d = (shadow_q << 8) | MAX_N'(cfg_data);
            cnt_d    = cnt_inc;
            state_d  = (cnt_inc == CNT_FULL) ? FULL : FILL;
          end
        end
        COMMIT: begin
          if (state_q == FULL && slen_q != 5'd0) state_d = APPLY;
          else                                   err_d   = 1'b1;
        end
        default: ;
      endcase
    end
    ready_d = (state_d != APPLY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      shadow_q <= '0;
      slen_q   <= '0;
      pat_q    <= '0;
      len_q    <= '0;
      armed_q  <= 1'b0;
      flush_q  <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      slen_q   <= slen_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      armed_q  <= armed_d;
      flush_q  <= flush_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign cfg_ready = ready_q;
  assign pattern   = pat_q;
  assign seq_len   = len_q;
  assign armed     = armed_q;
  assign det_flush = flush_q;
  assign cfg_err   = err_q;
  assign byte_cnt  = cnt_q;

endmodule

// File: tb/tb_seq_cfg_loader.sv
// Bench for seq_cfg_loader: command tasks, flush scoreboard,
// and per-scenario inline checks.
module tb_seq_cfg_loader;

  import seq_det_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_cmd;
  logic [7:0]  cfg_data;
  logic [31:0] pattern;
  logic [4:0]  seq_len;
  logic        armed;
  logic        det_flush;
  logic        cfg_err;
  logic [2:0]  byte_cnt;

  int tests = 0;
  int fails = 0;
  int flushes = 0;

  logic [37:0] sbq[$];

  logic [31:0] m_shadow;
  logic [4:0]  m_len;
  int          m_cnt;

  seq_cfg_loader #(.MAX_N(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_cmd(cfg_cmd),
    .cfg_data(cfg_data),
    .pattern(pattern),
    .seq_len(seq_len),
    .armed(armed),
    .det_flush(det_flush),
    .cfg_err(cfg_err),
    .byte_cnt(byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each flush pulse must match the next expected active snapshot.
  always @(negedge clk) begin
    if (rst_n && det_flush) begin
      flushes++;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL flush_unexpected got pat=%h len=%0d armed=%b exp none",
                 pattern, seq_len, armed);
      end else begin
        logic [37:0] e;
        e = sbq.pop_front();
        if ({pattern, seq_len, armed} !== e) begin
          fails++;
          $display("FAIL flush_snapshot got %h/%0d/%b exp %h/%0d/%b",
                   pattern, seq_len, armed, e[37:6], e[5:1], e[0]);
        end
      end
    end
  end

  task automatic model_reset();
    m_shadow = '0;
    m_len    = '0;
    m_cnt    = 0;
    sbq.delete();
  endtask

  task automatic model_update(input logic [1:0] cmd,
                              input logic [7:0] data);
    if (cmd == 2'(CLEAR)) begin
      m_shadow = '0;
      m_len    = '0;
      m_cnt    = 0;
      sbq.push_back(38'd0);
    end else if (cmd == 2'(LOAD_LEN)) begin
      if (data[7:5] == 3'd0) m_len = data[4:0];
    end else if (cmd == 2'(LOAD_BYTE)) begin
      if (m_cnt < 4) begin
        m_shadow = {m_shadow[23:0], data};
        m_cnt++;
      end
    end else begin
      if (m_cnt == 4 && m_len != 5'd0) begin
        sbq.push_back({m_shadow, m_len, 1'b1});
        m_cnt = 0;
      end
    end
  endtask

  task automatic send(input logic [1:0] cmd, input logic [7:0] data,
                      input bit hold, output int waits);
    bit r;
    bit ok;
    cfg_valid = 1'b1;
    cfg_cmd   = cmd;
    cfg_data  = data;
    waits = 0;
    ok = 1'b0;
    for (int k = 0; k < 16 && !ok; k++) begin
      @(negedge clk);
      r = cfg_ready;
      @(posedge clk);
      if (r) ok = 1'b1;
      else   waits++;
    end
    #1;
    if (!hold) cfg_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout got waits=%0d exp accepted", waits);
    end else begin
      model_update(cmd, data);
    end
  endtask

  task automatic cmd1(input logic [1:0] cmd, input logic [7:0] data);
    int w;
    send(cmd, data, 1'b0, w);
  endtask

  task automatic load4(input logic [31:0] v);
    cmd1(2'(LOAD_BYTE), v[31:24]);
    cmd1(2'(LOAD_BYTE), v[23:16]);
    cmd1(2'(LOAD_BYTE), v[15:8]);
    cmd1(2'(LOAD_BYTE), v[7:0]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_cmd = 2'b00;
    cfg_data = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (pattern !== 32'h0) begin
      fails++; $display("FAIL reset_pattern got %h exp 0", pattern);
    end
    tests++;
    if (seq_len !== 5'd0 || armed !== 1'b0) begin
      fails++; $display("FAIL reset_len_armed got %0d/%b exp 0/0", seq_len, armed);
    end
    tests++;
    if (det_flush !== 1'b0 || cfg_err !== 1'b0) begin
      fails++; $display("FAIL reset_flush_err got %b/%b exp 0/0", det_flush, cfg_err);
    end
    tests++;
    if (cfg_ready !== 1'b1 || byte_cnt !== 3'd0) begin
      fails++; $display("FAIL reset_ready_cnt got %b/%0d exp 1/0", cfg_ready, byte_cnt);
    end
  endtask

  task automatic test_commit();
    load4(32'hDEADBEEF);
    cmd1(2'(LOAD_LEN), 8'h10);
    tests++;
    if (byte_cnt !== 3'd4) begin
      fails++; $display("FAIL commit_cnt got %0d exp 4", byte_cnt);
    end
    cmd1(2'(COMMIT), 8'h00);
    tests++;
    if (cfg_ready !== 1'b0 || armed !== 1'b0 || pattern !== 32'h0) begin
      fails++;
      $display("FAIL commit_apply got rdy=%b armed=%b pat=%h exp 0/0/0",
               cfg_ready, armed, pattern);
    end
    @(posedge clk); #1;
    tests++;
    if (pattern !== 32'hDEADBEEF || seq_len !== 5'd16) begin
      fails++; $display("FAIL commit_active got %h/%0d exp deadbeef/16", pattern, seq_len);
    end
    tests++;
    if (armed !== 1'b1 || det_flush !== 1'b1 || cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL commit_flags got armed=%b flush=%b rdy=%b exp 1/1/1",
               armed, det_flush, cfg_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (det_flush !== 1'b0 || byte_cnt !== 3'd0) begin
      fails++; $display("FAIL commit_flush_end got %b/%0d exp 0/0", det_flush, byte_cnt);
    end
  endtask

  task automatic test_short_commit();
    cmd1(2'(LOAD_BYTE), 8'h11);
    cmd1(2'(LOAD_BYTE), 8'h22);
    cmd1(2'(LOAD_BYTE), 8'h33);
    cmd1(2'(COMMIT), 8'h00);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (cfg_err !== 1'b1 || byte_cnt !== 3'd3) begin
      fails++; $display("FAIL short_err got err=%b cnt=%0d exp 1/3", cfg_err, byte_cnt);
    end
    tests++;
    if (pattern !== 32'hDEADBEEF || seq_len !== 5'd16 || armed !== 1'b1) begin
      fails++;
      $display("FAIL short_active got %h/%0d/%b exp deadbeef/16/1",
               pattern, seq_len, armed);
    end
  endtask

  task automatic test_overflow();
    cmd1(2'(CLEAR), 8'h00);
    tests++;
    if (cfg_err !== 1'b0) begin
      fails++; $display("FAIL ovf_clear_err got %b exp 0", cfg_err);
    end
    cmd1(2'(LOAD_LEN), 8'h1F);
    load4(32'hCAFEBABE);
    cmd1(2'(LOAD_BYTE), 8'h55);
    tests++;
    if (cfg_err !== 1'b1 || byte_cnt !== 3'd4) begin
      fails++; $display("FAIL ovf_err got err=%b cnt=%0d exp 1/4", cfg_err, byte_cnt);
    end
    cmd1(2'(COMMIT), 8'h00);
    @(posedge clk); #1;
    tests++;
    if (pattern !== 32'hCAFEBABE || seq_len !== 5'd31) begin
      fails++; $display("FAIL ovf_active got %h/%0d exp cafebabe/31", pattern, seq_len);
    end
  endtask

  task automatic test_len_err_clear();
    cmd1(2'(CLEAR), 8'h00);
    cmd1(2'(LOAD_LEN), 8'h0A);
    tests++;
    if (cfg_err !== 1'b0) begin
      fails++; $display("FAIL len_ok_err got %b exp 0", cfg_err);
    end
    cmd1(2'(LOAD_LEN), 8'h21);
    tests++;
    if (cfg_err !== 1'b1) begin
      fails++; $display("FAIL len_33_err got %b exp 1", cfg_err);
    end
    cmd1(2'(LOAD_LEN), 8'hE4);
    load4(32'h0BADF00D);
    cmd1(2'(COMMIT), 8'h00);
    @(posedge clk); #1;
    tests++;
    if (pattern !== 32'h0BADF00D || seq_len !== 5'd10 || cfg_err !== 1'b1) begin
      fails++;
      $display("FAIL len_kept got %h/%0d err=%b exp 0badf00d/10 err=1",
               pattern, seq_len, cfg_err);
    end
    cmd1(2'(CLEAR), 8'h00);
    tests++;
    if (pattern !== 32'h0 || seq_len !== 5'd0 || armed !== 1'b0) begin
      fails++; $display("FAIL clear_active got %h/%0d/%b exp 0/0/0", pattern, seq_len, armed);
    end
    tests++;
    if (cfg_err !== 1'b0 || det_flush !== 1'b1) begin
      fails++; $display("FAIL clear_flags got err=%b flush=%b exp 0/1", cfg_err, det_flush);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int w;
    int f0;
    cmd1(2'(LOAD_LEN), 8'h05);
    load4(32'h01020304);
    f0 = flushes;
    send(2'(COMMIT), 8'h00, 1'b1, w);
    tests++;
    if (cfg_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_ready got %b exp 0", cfg_ready);
    end
    send(2'(LOAD_BYTE), 8'h12, 1'b0, w);
    tests++;
    if (w != 1) begin
      fails++; $display("FAIL b2b_stall got %0d exp 1", w);
    end
    tests++;
    if (byte_cnt !== 3'd1 || pattern !== 32'h01020304) begin
      fails++; $display("FAIL b2b_state got cnt=%0d pat=%h exp 1/01020304", byte_cnt, pattern);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (flushes - f0 != 1) begin
      fails++; $display("FAIL b2b_flush_count got %0d exp 1", flushes - f0);
    end
  endtask

  task automatic test_async_reset();
    cmd1(2'(CLEAR), 8'h00);
    cmd1(2'(LOAD_LEN), 8'h07);
    load4(32'hA5A5F00F);
    cmd1(2'(COMMIT), 8'h00);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (pattern !== 32'h0 || armed !== 1'b0 || det_flush !== 1'b0) begin
      fails++; $display("FAIL arst_now got %h/%b/%b exp 0/0/0", pattern, armed, det_flush);
    end
    tests++;
    if (cfg_ready !== 1'b1 || byte_cnt !== 3'd0) begin
      fails++; $display("FAIL arst_ready got %b/%0d exp 1/0", cfg_ready, byte_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (pattern !== 32'h0 || armed !== 1'b0 || seq_len !== 5'd0) begin
      fails++; $display("FAIL arst_after got %h/%b/%0d exp 0/0/0", pattern, armed, seq_len);
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_short_commit();
    test_overflow();
    test_len_err_clear();
    test_back_to_back();
    test_async_reset();
    tests++;
    if (sbq.size() != 0) begin
      fails++; $display("FAIL sb_drain got %0d pending exp 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
